seg7_decoder: RTL and testbench

- Registered BCD-to-7-segment decoder: 4-bit input code {b3,b2,b1,b0} drives segment outputs a..g for a single digit.
- Sits between digit-select/counter logic and the display pins.
- Adds lamp-test and blanking controls, a configurable output polarity, and an invalid-code flag.
- All outputs registered; one clock of latency.

---
 rtl/seg7_decoder_if.sv | 38 +++
 rtl/seg7_decoder.sv | 92 +++++++++
 tb/tb_seg7_decoder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seg7_decoder_if.sv
// rtl/seg7_decoder_if.sv - signal bundle between digit logic and the 7-segment decoder
//
// Purpose: groups the code/control inputs and the segment/flag outputs of one
//          seg7_decoder digit so they travel as one port.
// Signals:
//   b0..b3  code bits, b0 is the LSB (master -> slave)
//   lt      lamp test, forces every segment lit (master -> slave)
//   blank   forces every segment dark (master -> slave)
//   a..g    registered segment outputs, polarity set by ACTIVE_LOW (slave -> master)
//   invalid registered flag: last sampled code was not displayable (slave -> master)
// Modports: master = code/control driver, slave = decoder.

interface seg7_decoder_if;
  logic b0;
  logic b1;
  logic b2;
  logic b3;
  logic lt;
  logic blank;
  logic a;
  logic b;
  logic c;
  logic d;
  logic e;
  logic f;
  logic g;
  logic invalid;

  modport master (
    output b0, b1, b2, b3, lt, blank,
    input  a, b, c, d, e, f, g, invalid
  );

  modport slave (
    input  b0, b1, b2, b3, lt, blank,
    output a, b, c, d, e, f, g, invalid
  );
endinterface

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - registered BCD-to-7-segment decoder with lamp test and blanking
//
// Purpose: decodes the 4-bit code {b3,b2,b1,b0} into segments a..g for one digit,
//          with lamp-test/blank overrides, selectable output polarity and an
//          invalid-code flag. All outputs registered, one clock of latency.
// Parameters:
//   ACTIVE_LOW  0 = segment lit when output is 1 (common cathode),
//               1 = a..g inverted (common anode); invalid is never inverted.
// Optional build macro:
//   SEG_HEX_EN  when defined, codes 10-15 show hex glyphs A b C d E F and
//               invalid stays 0; otherwise they blank the digit and set invalid.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset (segments dark, invalid 0)
//   seg    seg7_decoder_if.slave: b0..b3, lt, blank in; a..g, invalid out

module seg7_decoder #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_decoder_if.slave seg
);

  // XOR mask applied last, so "dark" and "lit" always mean the same thing
  // upstream of the polarity stage.
  localparam logic [6:0] POL_MASK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

  logic [3:0] code;
  logic [6:0] glyph;       // abcdefg, MSB = a, active-high
  logic       glyph_bad;
  logic [6:0] lit_next;
  logic [6:0] seg_q;
  logic       invalid_q;

  assign code = {seg.b3, seg.b2, seg.b1, seg.b0};

  always_comb begin
    glyph     = 7'b0000000;
    glyph_bad = 1'b0;
    case (code)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
`ifdef SEG_HEX_EN
      4'd10:   glyph = 7'b1110111;
      4'd11:   glyph = 7'b0011111;
      4'd12:   glyph = 7'b1001110;
      4'd13:   glyph = 7'b0111101;
      4'd14:   glyph = 7'b1001111;
      4'd15:   glyph = 7'b1000111;
      default: glyph = 7'b0000000;
`else
      default: begin
        glyph     = 7'b0000000;
        glyph_bad = 1'b1;
      end
`endif
    endcase
  end

  // Lamp test beats blank, blank beats the decoded glyph.
  always_comb begin
    lit_next = glyph;
    if (seg.lt) begin
      lit_next = 7'b1111111;
    end else if (seg.blank) begin
      lit_next = 7'b0000000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q     <= POL_MASK;
      invalid_q <= 1'b0;
    end else begin
      seg_q     <= lit_next ^ POL_MASK;
      invalid_q <= glyph_bad;  // depends on the code only, not lt/blank
    end
  end

  assign {seg.a, seg.b, seg.c, seg.d, seg.e, seg.f, seg.g} = seg_q;
  assign seg.invalid = invalid_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// tb/tb_seg7_decoder.sv - directed self-checking bench for seg7_decoder (both polarities)

module tb_seg7_decoder;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  seg7_decoder_if if_hi ();
  seg7_decoder_if if_lo ();

  seg7_decoder #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .seg   (if_hi.slave)
  );

  seg7_decoder #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .seg   (if_lo.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written lit patterns, abcdefg MSB-first.
  logic [6:0] dig_tab [0:9];
  logic [6:0] hex_tab [10:15];

  task automatic drive(input logic [3:0] code, input logic lt_i, input logic blank_i,
                       input logic rst_i);
    rst_n = rst_i;
    {if_hi.b3, if_hi.b2, if_hi.b1, if_hi.b0} = code;
    {if_lo.b3, if_lo.b2, if_lo.b1, if_lo.b0} = code;
    if_hi.lt    = lt_i;
    if_lo.lt    = lt_i;
    if_hi.blank = blank_i;
    if_lo.blank = blank_i;
  endtask

  task automatic step(input logic [3:0] code, input logic lt_i, input logic blank_i,
                      input logic rst_i);
    drive(code, lt_i, blank_i, rst_i);
    @(posedge clk);
    #1;
  endtask

  // Checks both instances: the active-low one must be the bitwise inverse.
  task automatic check(input string tag, input logic [6:0] exp_lit, input logic exp_inv);
    logic [6:0] obs_hi;
    logic [6:0] obs_lo;
    obs_hi = {if_hi.a, if_hi.b, if_hi.c, if_hi.d, if_hi.e, if_hi.f, if_hi.g};
    obs_lo = {if_lo.a, if_lo.b, if_lo.c, if_lo.d, if_lo.e, if_lo.f, if_lo.g};
    tests++;
    assert (obs_hi === exp_lit) else begin
      fails++;
      $error("FAIL %s seg_hi: observed %b expected %b", tag, obs_hi, exp_lit);
    end
    tests++;
    assert (obs_lo === ~exp_lit) else begin
      fails++;
      $error("FAIL %s seg_lo: observed %b expected %b", tag, obs_lo, ~exp_lit);
    end
    tests++;
    assert (if_hi.invalid === exp_inv) else begin
      fails++;
      $error("FAIL %s inv_hi: observed %b expected %b", tag, if_hi.invalid, exp_inv);
    end
    tests++;
    assert (if_lo.invalid === exp_inv) else begin
      fails++;
      $error("FAIL %s inv_lo: observed %b expected %b", tag, if_lo.invalid, exp_inv);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    dig_tab[0] = 7'b1111110; dig_tab[1] = 7'b0110000; dig_tab[2] = 7'b1101101;
    dig_tab[3] = 7'b1111001; dig_tab[4] = 7'b0110011; dig_tab[5] = 7'b1011011;
    dig_tab[6] = 7'b1011111; dig_tab[7] = 7'b1110000; dig_tab[8] = 7'b1111111;
    dig_tab[9] = 7'b1111011;
    hex_tab[10] = 7'b1110111; hex_tab[11] = 7'b0011111; hex_tab[12] = 7'b1001110;
    hex_tab[13] = 7'b0111101; hex_tab[14] = 7'b1001111; hex_tab[15] = 7'b1000111;

    // Reset held two edges with code 8 and lamp test: still dark.
    step(4'd8, 1'b1, 1'b0, 1'b0);
    check("reset_1", 7'b0000000, 1'b0);
    step(4'd8, 1'b1, 1'b0, 1'b0);
    check("reset_2", 7'b0000000, 1'b0);

    // First edge after release decodes the code present at that edge.
    step(4'd3, 1'b0, 1'b0, 1'b1);
    check("release_3", 7'b1111001, 1'b0);

    // Outputs hold between edges even when inputs move.
    drive(4'd8, 1'b1, 1'b0, 1'b1);
    #2;
    check("hold_between_edges", 7'b1111001, 1'b0);

    // Back-to-back sweep of the decimal digits.
    for (int i = 0; i < 10; i++) begin
      step(4'(i), 1'b0, 1'b0, 1'b1);
      check($sformatf("digit_%0d", i), dig_tab[i], 1'b0);
    end

    // Codes 10..15.
    for (int i = 10; i < 16; i++) begin
      step(4'(i), 1'b0, 1'b0, 1'b1);
`ifdef SEG_HEX_EN
      check($sformatf("hex_%0d", i), hex_tab[i], 1'b0);
`else
      check($sformatf("oor_%0d", i), 7'b0000000, 1'b1);
`endif
    end

    // Priority: lt > blank > decode.
    step(4'd1, 1'b1, 1'b1, 1'b1);
    check("prio_lt_blank", 7'b1111111, 1'b0);
    step(4'd1, 1'b0, 1'b1, 1'b1);
    check("prio_blank", 7'b0000000, 1'b0);
    step(4'd1, 1'b0, 1'b0, 1'b1);
    check("prio_decode", 7'b0110000, 1'b0);

    // invalid follows the code even under lamp test / blank.
`ifdef SEG_HEX_EN
    step(4'd12, 1'b1, 1'b0, 1'b1);
    check("inv_under_lt", 7'b1111111, 1'b0);
    step(4'd15, 1'b0, 1'b1, 1'b1);
    check("inv_under_blank", 7'b0000000, 1'b0);
`else
    step(4'd12, 1'b1, 1'b0, 1'b1);
    check("inv_under_lt", 7'b1111111, 1'b1);
    step(4'd13, 1'b0, 1'b1, 1'b1);
    check("inv_under_blank", 7'b0000000, 1'b1);
`endif

    // Reset while invalid is set clears it.
    step(4'd14, 1'b1, 1'b1, 1'b0);
    check("reset_clears_inv", 7'b0000000, 1'b0);

    // Mid-sweep reset for one edge at code 7, then resume.
    step(4'd5, 1'b0, 1'b0, 1'b1);
    check("mid_5", dig_tab[5], 1'b0);
    step(4'd6, 1'b0, 1'b0, 1'b1);
    check("mid_6", dig_tab[6], 1'b0);
    step(4'd7, 1'b0, 1'b0, 1'b0);
    check("mid_rst_7", 7'b0000000, 1'b0);
    step(4'd8, 1'b0, 1'b0, 1'b1);
    check("mid_8", dig_tab[8], 1'b0);
    step(4'd9, 1'b0, 1'b0, 1'b1);
    check("mid_9", dig_tab[9], 1'b0);
    step(4'd0, 1'b0, 1'b0, 1'b1);
    check("mid_0", dig_tab[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
